branch_issue_ctrl: RTL and testbench

BRANCH_ISSUE_CTRL -- requirements
Module: branch_issue_ctrl

---
 rtl/isa_pkg.sv | 20 ++
 rtl/branch_queue.sv | 59 +++++
 rtl/branch_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_branch_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared types for the branch issue path: controller state and queued branch payload.
package isa_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned BR_TYPE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } branch_ctrl_state_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [BR_TYPE_W-1:0] br_type;
    logic                 pred;
  } branch_entry_t;

endpackage

// File: rtl/branch_queue.sv
// In-order branch FIFO; pointers wrap naturally because DEPTH is a power of two.
module branch_queue
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_clear,
  input  branch_entry_t                  i_data,
  output logic                           o_full,
  output logic                           o_empty,
  output branch_entry_t                  o_head,
  output logic [$clog2(DEPTH):0]         o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  branch_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/branch_issue_ctrl.sv
// Branch issue controller: queues dispatched branches, issues the head to the branch FU
// once operands arrive, and flushes/redirects fetch on a misprediction.
module branch_issue_ctrl
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [XLEN-1:0]      enq_pc,
  input  logic [XLEN-1:0]      enq_imm,
  input  logic [BR_TYPE_W-1:0] enq_type,
  input  logic                 enq_pred,
  input  logic                 ops_valid,
  input  logic [XLEN-1:0]      ops_reg_a,
  input  logic [XLEN-1:0]      ops_reg_b,
  output logic                 fu_branch,
  output logic                 fu_enable,
  output logic [XLEN-1:0]      fu_pc,
  output logic [XLEN-1:0]      fu_imm,
  output logic [BR_TYPE_W-1:0] fu_type,
  output logic                 fu_pred,
  output logic [XLEN-1:0]      fu_reg_a,
  output logic [XLEN-1:0]      fu_reg_b,
  input  logic                 fu_resolved,
  input  logic                 fu_misprediction,
  input  logic [XLEN-1:0]      fu_correct_pc,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  branch_ctrl_state_t r_state;
  branch_ctrl_state_t w_state_next;
  logic               r_enq_ready;
  logic               r_fu_branch;
  branch_entry_t      r_fu_entry;
  logic [XLEN-1:0]    r_fu_reg_a;
  logic [XLEN-1:0]    r_fu_reg_b;
  logic               r_flush;
  logic [XLEN-1:0]    r_redirect_pc;

  logic               w_push;
  logic               w_pop;
  logic               w_clear;
  logic               w_issue;
  logic               w_full;
  logic               w_empty;
  branch_entry_t      w_head;
  branch_entry_t      w_enq_entry;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_next;

  assign w_enq_entry = '{pc: enq_pc, imm: enq_imm, br_type: enq_type, pred: enq_pred};
  assign w_push      = enq_valid && r_enq_ready && !w_full;

  branch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (CLK),
    .rst_n   (nRST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (w_enq_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_clear      = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && ops_valid) begin
          w_issue      = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (fu_resolved) begin
          w_pop        = 1'b1;
          w_state_next = fu_misprediction ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        w_clear      = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Mirror of the queue count one edge ahead, so enq_ready can be a flop.
  always_comb begin
    w_count_next = w_count;
    if (w_clear) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = w_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= IDLE;
      r_enq_ready   <= 1'b0;
      r_fu_branch   <= 1'b0;
      r_fu_entry    <= '0;
      r_fu_reg_a    <= '0;
      r_fu_reg_b    <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state     <= w_state_next;
      r_enq_ready <= (w_count_next < CNT_W'(DEPTH)) && (w_state_next != FLUSH);
      r_fu_branch <= (w_state_next == ISSUE);
      r_flush     <= (w_state_next == FLUSH);
      // Head entry and operands captured on issue; the head cannot move while in ISSUE.
      if (w_issue) begin
        r_fu_entry <= w_head;
        r_fu_reg_a <= ops_reg_a;
        r_fu_reg_b <= ops_reg_b;
      end else if (w_state_next != ISSUE) begin
        r_fu_entry <= '0;
        r_fu_reg_a <= '0;
        r_fu_reg_b <= '0;
      end
      if ((r_state == ISSUE) && fu_resolved && fu_misprediction) begin
        r_redirect_pc <= fu_correct_pc;
      end
    end
  end

  assign enq_ready      = r_enq_ready;
  assign fu_branch      = r_fu_branch;
  assign fu_enable      = r_fu_branch;
  assign fu_pc          = r_fu_entry.pc;
  assign fu_imm         = r_fu_entry.imm;
  assign fu_type        = r_fu_entry.br_type;
  assign fu_pred        = r_fu_entry.pred;
  assign fu_reg_a       = r_fu_reg_a;
  assign fu_reg_b       = r_fu_reg_b;
  assign flush          = r_flush;
  assign redirect_valid = r_flush;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Directed bench for branch_issue_ctrl: issue, mispredict flush, backpressure, reset, wrap.
module tb_branch_issue_ctrl;

  logic        CLK;
  logic        nRST;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_imm;
  logic [2:0]  enq_type;
  logic        enq_pred;
  logic        ops_valid;
  logic [31:0] ops_reg_a;
  logic [31:0] ops_reg_b;
  logic        fu_branch;
  logic        fu_enable;
  logic [31:0] fu_pc;
  logic [31:0] fu_imm;
  logic [2:0]  fu_type;
  logic        fu_pred;
  logic [31:0] fu_reg_a;
  logic [31:0] fu_reg_b;
  logic        fu_resolved;
  logic        fu_misprediction;
  logic [31:0] fu_correct_pc;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks;
  int failures;

  branch_issue_ctrl #(.DEPTH(4)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .enq_valid        (enq_valid),
    .enq_ready        (enq_ready),
    .enq_pc           (enq_pc),
    .enq_imm          (enq_imm),
    .enq_type         (enq_type),
    .enq_pred         (enq_pred),
    .ops_valid        (ops_valid),
    .ops_reg_a        (ops_reg_a),
    .ops_reg_b        (ops_reg_b),
    .fu_branch        (fu_branch),
    .fu_enable        (fu_enable),
    .fu_pc            (fu_pc),
    .fu_imm           (fu_imm),
    .fu_type          (fu_type),
    .fu_pred          (fu_pred),
    .fu_reg_a         (fu_reg_a),
    .fu_reg_b         (fu_reg_b),
    .fu_resolved      (fu_resolved),
    .fu_misprediction (fu_misprediction),
    .fu_correct_pc    (fu_correct_pc),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [2:0] ty, input logic pr);
    enq_valid = v;
    enq_pc    = pc;
    enq_imm   = imm;
    enq_type  = ty;
    enq_pred  = pr;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nRST = 1'b0;
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    ops_valid = 1'b0;
    ops_reg_a = 32'h0;
    ops_reg_b = 32'h0;
    fu_resolved = 1'b0;
    fu_misprediction = 1'b0;
    fu_correct_pc = 32'h0;

    // Reset values
    #3;
    chk("rst_enq_ready", 32'(enq_ready), 32'd0);
    chk("rst_fu_branch", 32'(fu_branch), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    tick();
    chk("post_rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("post_rst_redirect_pc", redirect_pc, 32'h0);

    // Single branch, mispredicted
    set_enq(1'b1, 32'h100, 32'h20, 3'd0, 1'b0);
    ops_valid = 1'b1;
    ops_reg_a = 32'd5;
    ops_reg_b = 32'd5;
    tick();
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    chk("a_idle_after_enq", 32'(fu_branch), 32'd0);
    tick();
    ops_valid = 1'b0;
    chk("a_fu_branch", 32'(fu_branch), 32'd1);
    chk("a_fu_enable", 32'(fu_enable), 32'd1);
    chk("a_fu_pc", fu_pc, 32'h100);
    chk("a_fu_imm", fu_imm, 32'h20);
    chk("a_fu_reg_a", fu_reg_a, 32'd5);
    chk("a_fu_reg_b", fu_reg_b, 32'd5);
    tick();
    chk("a_hold_fu_branch", 32'(fu_branch), 32'd1);
    chk("a_hold_fu_pc", fu_pc, 32'h100);
    fu_resolved = 1'b1;
    fu_misprediction = 1'b1;
    fu_correct_pc = 32'h120;
    tick();
    fu_resolved = 1'b0;
    fu_misprediction = 1'b0;
    chk("a_flush", 32'(flush), 32'd1);
    chk("a_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("a_redirect_pc", redirect_pc, 32'h120);
    chk("a_fu_branch_in_flush", 32'(fu_branch), 32'd0);
    chk("a_fu_pc_in_flush", fu_pc, 32'h0);
    chk("a_enq_ready_in_flush", 32'(enq_ready), 32'd0);
    tick();
    chk("a_flush_drop", 32'(flush), 32'd0);
    chk("a_redirect_valid_drop", 32'(redirect_valid), 32'd0);
    chk("a_enq_ready_after", 32'(enq_ready), 32'd1);
    ops_valid = 1'b1;
    tick();
    tick();
    chk("a_queue_empty", 32'(fu_branch), 32'd0);
    ops_valid = 1'b0;

    // Three correct branches, back to back
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h200 + 32'(4 * i), 32'h8, 3'(i + 1), 1'b1);
      tick();
    end
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    ops_valid = 1'b1;
    fu_resolved = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("c_flush_never", 32'(flush), 32'd0);
      if (c % 2 == 0) begin
        chk("c_fu_branch_issue", 32'(fu_branch), 32'd1);
        chk("c_fu_pc_order", fu_pc, 32'h200 + 32'(2 * c));
        chk("c_fu_type", 32'(fu_type), 32'(c / 2 + 1));
      end else begin
        chk("c_fu_branch_idle", 32'(fu_branch), 32'd0);
      end
    end
    tick();
    chk("c_drained", 32'(fu_branch), 32'd0);
    ops_valid = 1'b0;
    fu_resolved = 1'b0;

    // Fill to DEPTH with operands unavailable, hold a fifth
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 32'h300 + 32'(4 * i), 32'h4, 3'd2, 1'b0);
      chk("b_enq_ready_fill", 32'(enq_ready), 32'd1);
      tick();
    end
    set_enq(1'b1, 32'h310, 32'h4, 3'd2, 1'b0);
    chk("b_full_ready", 32'(enq_ready), 32'd0);
    tick();
    chk("b_held_ready", 32'(enq_ready), 32'd0);
    ops_valid = 1'b1;
    tick();
    chk("b_issue_pc", fu_pc, 32'h300);
    chk("b_ready_in_issue", 32'(enq_ready), 32'd0);
    ops_valid = 1'b0;
    fu_resolved = 1'b1;
    tick();
    fu_resolved = 1'b0;
    chk("b_ready_after_pop", 32'(enq_ready), 32'd1);
    tick();
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    chk("b_full_again", 32'(enq_ready), 32'd0);
    ops_valid = 1'b1;
    fu_resolved = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b_drain_issue", 32'(fu_branch), 32'd1);
      chk("b_drain_pc", fu_pc, 32'h304 + 32'(4 * k));
      tick();
      chk("b_drain_idle", 32'(fu_branch), 32'd0);
    end
    ops_valid = 1'b0;
    fu_resolved = 1'b0;

    // Mispredict with three younger entries queued
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 32'h400 + 32'(4 * i), 32'h10, 3'd1, 1'b1);
      tick();
    end
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    ops_valid = 1'b1;
    tick();
    chk("d_issue_pc", fu_pc, 32'h400);
    fu_resolved = 1'b1;
    fu_misprediction = 1'b1;
    fu_correct_pc = 32'h500;
    tick();
    fu_resolved = 1'b0;
    fu_misprediction = 1'b0;
    set_enq(1'b1, 32'h600, 32'h0, 3'd3, 1'b0);
    chk("d_flush", 32'(flush), 32'd1);
    chk("d_redirect_pc", redirect_pc, 32'h500);
    chk("d_enq_ready_flush", 32'(enq_ready), 32'd0);
    tick();
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    chk("d_flush_drop", 32'(flush), 32'd0);
    chk("d_enq_ready_after", 32'(enq_ready), 32'd1);
    tick();
    tick();
    chk("d_all_dropped", 32'(fu_branch), 32'd0);
    ops_valid = 1'b0;

    // Reset asserted during ISSUE
    set_enq(1'b1, 32'h700, 32'h4, 3'd5, 1'b1);
    tick();
    set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    ops_valid = 1'b1;
    tick();
    chk("e_in_issue", 32'(fu_branch), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("e_fu_branch_async", 32'(fu_branch), 32'd0);
    chk("e_fu_pc_async", fu_pc, 32'h0);
    chk("e_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("e_redirect_pc", redirect_pc, 32'h0);
    chk("e_enq_ready_rst", 32'(enq_ready), 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    chk("e_enq_ready_post", 32'(enq_ready), 32'd1);
    tick();
    tick();
    chk("e_count_zero", 32'(fu_branch), 32'd0);
    chk("e_no_flush", 32'(flush), 32'd0);
    ops_valid = 1'b0;

    // Ten enqueue/resolve pairs wrap the pointers
    for (int i = 0; i < 10; i++) begin
      set_enq(1'b1, 32'h1000 + 32'(4 * i), 32'(i), 3'(i), 1'(i));
      ops_reg_a = 32'(i * 3);
      chk("f_enq_ready", 32'(enq_ready), 32'd1);
      tick();
      set_enq(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      ops_valid = 1'b1;
      tick();
      chk("f_fu_pc", fu_pc, 32'h1000 + 32'(4 * i));
      chk("f_fu_type", 32'(fu_type), 32'(i % 8));
      chk("f_fu_pred", 32'(fu_pred), 32'(i % 2));
      chk("f_fu_reg_a", fu_reg_a, 32'(i * 3));
      ops_valid = 1'b0;
      fu_resolved = 1'b1;
      tick();
      fu_resolved = 1'b0;
      chk("f_idle", 32'(fu_branch), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
